// File: rtl/tank_move_ctrl.sv
// tank_move_ctrl: frame-paced move/turn sequencer for the tank sprite drawer.
// Accepts one command at a time and commits it during vertical blanking.
module tank_move_ctrl #(
    parameter int X_INIT      = 376,
    parameter int Y_INIT      = 268,
    parameter int DIR_INIT    = 0,
    parameter int STEP        = 2,
    parameter int X_MAX       = 800,
    parameter int Y_MAX       = 600,
    parameter int TANK_W      = 48,
    parameter int TANK_L      = 64,
    parameter int TURN_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vblnk_in,
    input  logic       move_req,
    input  logic [1:0] move_dir,
    output logic       move_ack,
    output logic       busy,
    output logic [9:0] xpos_tank_out,
    output logic [9:0] ypos_tank_out,
    output logic [1:0] direction_out,
    output logic       update_pulse
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PEND   = 3'd1;
    localparam logic [2:0] S_TURN   = 3'd2;
    localparam logic [2:0] S_MOVE   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    localparam int CW = (TURN_FRAMES < 2) ? 1 : $clog2(TURN_FRAMES);
    localparam logic [CW-1:0] TURN_LAST = CW'(TURN_FRAMES - 1);

    localparam logic [9:0] STEP_V   = 10'(STEP);
    // Right/bottom limits of the top-left corner for each footprint.
    localparam logic [9:0] XL_NARROW = 10'(X_MAX - TANK_W);
    localparam logic [9:0] XL_WIDE   = 10'(X_MAX - TANK_L);
    localparam logic [9:0] YL_TALL   = 10'(Y_MAX - TANK_L);
    localparam logic [9:0] YL_SHORT  = 10'(Y_MAX - TANK_W);

    logic       q1;
    logic       q2;
    logic       tick;
    logic [2:0] state;
    logic [1:0] cmd_dir;
    logic [CW-1:0] turn_cnt;
    logic [9:0] cand_x;
    logic [9:0] cand_y;
    logic [1:0] cand_dir;
    logic [9:0] cur_lim_x;
    logic [9:0] cur_lim_y;
    logic [9:0] new_lim_x;
    logic [9:0] new_lim_y;
    logic [9:0] mv_x;
    logic [9:0] mv_y;
    logic [9:0] tn_x;
    logic [9:0] tn_y;

    assign tick = q1 & ~q2;

    // Directions 2/3 (left/right) lie the sprite on its long side.
    assign cur_lim_x = direction_out[1] ? XL_WIDE  : XL_NARROW;
    assign cur_lim_y = direction_out[1] ? YL_SHORT : YL_TALL;
    assign new_lim_x = cmd_dir[1] ? XL_WIDE  : XL_NARROW;
    assign new_lim_y = cmd_dir[1] ? YL_SHORT : YL_TALL;

    // Re-clamp the current position into the footprint of the new direction.
    assign tn_x = (xpos_tank_out > new_lim_x) ? new_lim_x : xpos_tank_out;
    assign tn_y = (ypos_tank_out > new_lim_y) ? new_lim_y : ypos_tank_out;

    // Candidate position for one step; overflow test done one bit wider.
    always_comb begin
        mv_x = xpos_tank_out;
        mv_y = ypos_tank_out;
        case (direction_out)
            2'd0: begin
                mv_y = (ypos_tank_out < STEP_V) ? 10'd0
                                                : ypos_tank_out - STEP_V;
            end
            2'd1: begin
                mv_y = (({1'b0, ypos_tank_out} + {1'b0, STEP_V})
                        > {1'b0, cur_lim_y}) ? cur_lim_y
                                             : ypos_tank_out + STEP_V;
            end
            2'd2: begin
                mv_x = (xpos_tank_out < STEP_V) ? 10'd0
                                                : xpos_tank_out - STEP_V;
            end
            default: begin
                mv_x = (({1'b0, xpos_tank_out} + {1'b0, STEP_V})
                        > {1'b0, cur_lim_x}) ? cur_lim_x
                                             : xpos_tank_out + STEP_V;
            end
        endcase
    end

    // Two-flop vblank synchroniser; its rising edge is the frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
        end else begin
            q1 <= vblnk_in;
            q2 <= q1;
        end
    end

    // Command FSM: accept, wait for a frame, step or turn, then commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cmd_dir  <= 2'd0;
            turn_cnt <= '0;
            cand_x   <= 10'(X_INIT);
            cand_y   <= 10'(Y_INIT);
            cand_dir <= 2'(DIR_INIT);
            move_ack <= 1'b0;
            busy     <= 1'b0;
        end else begin
            move_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (move_req) begin
                        cmd_dir  <= move_dir;
                        move_ack <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (tick) begin
                        if (cmd_dir == direction_out) begin
                            state <= S_MOVE;
                        end else begin
                            turn_cnt <= '0;
                            state    <= S_TURN;
                        end
                    end
                end
                S_TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        cand_x   <= tn_x;
                        cand_y   <= tn_y;
                        cand_dir <= cmd_dir;
                        state    <= S_COMMIT;
                    end else if (tick) begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                S_MOVE: begin
                    cand_x   <= mv_x;
                    cand_y   <= mv_y;
                    cand_dir <= direction_out;
                    state    <= S_COMMIT;
                end
                S_COMMIT: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Drawer-facing registers only move in COMMIT, flagged by update_pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpos_tank_out <= 10'(X_INIT);
            ypos_tank_out <= 10'(Y_INIT);
            direction_out <= 2'(DIR_INIT);
            update_pulse  <= 1'b0;
        end else if (state == S_COMMIT) begin
            xpos_tank_out <= cand_x;
            ypos_tank_out <= cand_y;
            direction_out <= cand_dir;
            update_pulse  <= 1'b1;
        end else begin
            update_pulse  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tank_move_ctrl.sv
// tb_tank_move_ctrl: two DUTs (default and offset start position) driven
// with identical commands and compared against a frame-level position model.
module tb_tank_move_ctrl;

    localparam int FL = 20;
    localparam int BL = 6;
    localparam int XM = 800;
    localparam int YM = 600;
    localparam int TW = 48;
    localparam int TL = 64;
    localparam int ST = 2;
    localparam int TF = 4;

    typedef struct {
        int d;
        int xa;
        int ya;
        int xb;
        int yb;
        int dir;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vblnk_in;
    logic       move_req;
    logic [1:0] move_dir;
    logic       ack_a, busy_a, up_a;
    logic       ack_b, busy_b, up_b;
    logic [9:0] x_a, y_a, x_b, y_b;
    logic [1:0] dir_a, dir_b;

    int total = 0;
    int bad = 0;
    int mx[2];
    int my[2];
    int md;
    int fcnt;

    tank_move_ctrl u_dut_a (
        .clk(clk), .rst_n(rst_n), .vblnk_in(vblnk_in),
        .move_req(move_req), .move_dir(move_dir),
        .move_ack(ack_a), .busy(busy_a),
        .xpos_tank_out(x_a), .ypos_tank_out(y_a),
        .direction_out(dir_a), .update_pulse(up_a)
    );

    tank_move_ctrl #(.X_INIT(750), .Y_INIT(269)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .vblnk_in(vblnk_in),
        .move_req(move_req), .move_dir(move_dir),
        .move_ack(ack_b), .busy(busy_b),
        .xpos_tank_out(x_b), .ypos_tank_out(y_b),
        .direction_out(dir_b), .update_pulse(up_b)
    );

    always #5 clk = ~clk;

    initial begin : vgen
        vblnk_in = 1'b0;
        fcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            fcnt = (fcnt + 1) % FL;
            vblnk_in = (fcnt >= FL - BL);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mx[0] = 376; my[0] = 268;
        mx[1] = 750; my[1] = 269;
        md = 0;
    endtask

    function automatic void model_cmd(input int d);
        int w, h;
        w = (d < 2) ? TW : TL;
        h = (d < 2) ? TL : TW;
        for (int i = 0; i < 2; i++) begin
            if (d == md) begin
                case (d)
                    0: my[i] = (my[i] < ST) ? 0 : my[i] - ST;
                    1: my[i] = (my[i] + ST > YM - h) ? YM - h : my[i] + ST;
                    2: mx[i] = (mx[i] < ST) ? 0 : mx[i] - ST;
                    default: mx[i] = (mx[i] + ST > XM - w) ? XM - w : mx[i] + ST;
                endcase
            end else begin
                if (mx[i] > XM - w) mx[i] = XM - w;
                if (my[i] > YM - h) my[i] = YM - h;
            end
        end
        md = d;
    endfunction

    task automatic chk_model(input string tag);
        chk({tag, "_xa"}, int'(x_a), mx[0]);
        chk({tag, "_ya"}, int'(y_a), my[0]);
        chk({tag, "_xb"}, int'(x_b), mx[1]);
        chk({tag, "_yb"}, int'(y_b), my[1]);
        chk({tag, "_dira"}, int'(dir_a), md);
        chk({tag, "_dirb"}, int'(dir_b), md);
    endtask

    task automatic chk_init(input string tag);
        chk({tag, "_xa"}, int'(x_a), 376);
        chk({tag, "_ya"}, int'(y_a), 268);
        chk({tag, "_xb"}, int'(x_b), 750);
        chk({tag, "_yb"}, int'(y_b), 269);
        chk({tag, "_dir"}, int'(dir_a), 0);
        chk({tag, "_ack"}, int'(ack_a), 0);
        chk({tag, "_busy"}, int'(busy_a), 0);
        chk({tag, "_upd"}, int'(up_a), 0);
    endtask

    task automatic wait_vb(input bit level);
        int n = 0;
        while (vblnk_in != level && n < 4 * FL) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_ack();
        int n = 0;
        @(negedge clk);
        while (!ack_a && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Issue one command; coinc=1 times the accept onto the frame tick.
    task automatic send(input int d, input bit coinc);
        int n, frames, since, exp_frames;
        bit prev;
        if (coinc) begin
            wait_vb(1'b0);
            wait_vb(1'b1);
            @(negedge clk);
        end else begin
            wait_vb(1'b1);
            wait_vb(1'b0);
            @(negedge clk);
        end
        move_req = 1'b1;
        move_dir = d[1:0];
        wait_ack();
        chk("ack_seen", int'(ack_a), 1);
        chk("ack_b", int'(ack_b), 1);
        chk("busy_at_ack", int'(busy_a), 1);
        move_req = 1'b0;
        move_dir = 2'($urandom_range(0, 3));
        if (ack_a) begin
            exp_frames = (d == md) ? 1 : TF;
            prev = vblnk_in;
            @(negedge clk);
            chk("ack_pulse", int'(ack_a), 0);
            frames = 0;
            since = 0;
            n = 0;
            while (!up_a && n < FL * (TF + 3)) begin
                if (vblnk_in && !prev) begin
                    frames++;
                    since = 0;
                end
                prev = vblnk_in;
                @(negedge clk);
                since++;
                n++;
            end
            chk("commit_seen", int'(up_a), 1);
            chk("commit_b", int'(up_b), 1);
            chk("frames", frames, exp_frames);
            chk("latency", since, 4);
            chk("busy_clr", int'(busy_a), 0);
            model_cmd(d);
            chk_model("cmd");
            @(negedge clk);
            chk("pulse_len", int'(up_a), 0);
        end
    endtask

    task automatic reset_mid_turn(input int d);
        int n = 0;
        int rises = 0;
        bit prev;
        wait_vb(1'b1);
        wait_vb(1'b0);
        @(negedge clk);
        move_req = 1'b1;
        move_dir = d[1:0];
        wait_ack();
        chk("mt_ack", int'(ack_a), 1);
        move_req = 1'b0;
        prev = vblnk_in;
        while (rises < 2 && n < FL * 4) begin
            @(negedge clk);
            if (vblnk_in && !prev) rises++;
            prev = vblnk_in;
            n++;
        end
        wait_vb(1'b0);
        repeat (3) @(negedge clk);
        chk("mt_busy", int'(busy_a), 1);
        chk("mt_dir_held", int'(dir_a), md);
        #2 rst_n = 1'b0;
        #1 chk_init("mt_rst");
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drawer outputs may only change together with update_pulse in vblank.
    initial begin : stab
        logic [43:0] prev_snap, snap;
        prev_snap = '0;
        forever begin
            @(negedge clk);
            snap = {x_a, y_a, dir_a, x_b, y_b, dir_b};
            if (rst_n && snap != prev_snap) begin
                total++;
                if (!(up_a && up_b && vblnk_in)) begin
                    bad++;
                    $display("FAIL out_stable actual upd=%0b vb=%0b required upd=1 vb=1",
                             up_a, vblnk_in);
                end
            end
            prev_snap = snap;
        end
    end

    initial begin : main
        vec_t tbl[10];
        int d;
        tbl[0] = '{0, 376, 266, 750, 267, 0};
        tbl[1] = '{1, 376, 266, 750, 267, 1};
        tbl[2] = '{1, 376, 268, 750, 269, 1};
        tbl[3] = '{3, 376, 268, 736, 269, 3};
        tbl[4] = '{3, 378, 268, 736, 269, 3};
        tbl[5] = '{2, 378, 268, 736, 269, 2};
        tbl[6] = '{2, 376, 268, 734, 269, 2};
        tbl[7] = '{0, 376, 268, 734, 269, 0};
        tbl[8] = '{0, 376, 266, 734, 267, 0};
        tbl[9] = '{0, 376, 264, 734, 265, 0};

        rst_n = 1'b1;
        move_req = 1'b0;
        move_dir = 2'd0;
        #3 rst_n = 1'b0;
        #1 chk_init("por");
        model_reset();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            send(tbl[i].d, 1'b0);
            chk("tbl_xa", int'(x_a), tbl[i].xa);
            chk("tbl_ya", int'(y_a), tbl[i].ya);
            chk("tbl_xb", int'(x_b), tbl[i].xb);
            chk("tbl_yb", int'(y_b), tbl[i].yb);
            chk("tbl_dir", int'(dir_a), tbl[i].dir);
        end

        send(0, 1'b1);
        send(3, 1'b1);

        reset_mid_turn(1);
        send(0, 1'b0);

        #2 rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 134; i++) send(0, 1'b0);
        chk("edge_y1", int'(y_b), 1);
        send(0, 1'b0);
        chk("edge_y0", int'(y_b), 0);
        send(0, 1'b0);
        chk("edge_y0_hold", int'(y_b), 0);
        send(3, 1'b0);
        chk("turn_clamp_x", int'(x_b), 736);
        chk("turn_keep_y", int'(y_b), 0);
        send(3, 1'b0);
        chk("right_bound_x", int'(x_b), 736);

        for (int i = 0; i < 40; i++) begin
            d = ($urandom_range(0, 2) != 0) ? md : int'($urandom_range(0, 3));
            send(d, 1'($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
